seg7_scan_ctrl: RTL
===================

// Module: seg7_scan_ctrl
// PURPOSE
//  Parametrised N-digit multiplexed seven-segment controller for the Basys-class display path.
//  Accepts a full hex frame (nibbles + dots) over a valid/ready handshake, throttles updates to
//  one per HOLD_TICKS refresh ticks, scans digits at the refresh rate, optionally blanks leading zeros.
//  Sits between packet/bus sources (PS/2 mouse, bus peripheral) and the board SEG/HEX pins.
// PARAMETERS
//  NUM_DIGITS   4        digits scanned (2..8)
//  REFRESH_DIV  250000   clk_sys cycles per digit slot (200 Hz @ 50 MHz)
//  HOLD_TICKS   200      refresh ticks between accepted frames when hold_en=1 (1 s)
// PORTS
//  clk_sys         in   1              system clock
//  rst             in   1              synchronous active-high reset
//  upd_vld         in   1              frame valid
//  upd_rdy         out  1              frame ready
//  upd_data        in   4*NUM_DIGITS   nibble per digit, digit 0 = [3:0] (rightmost)
//  upd_dots        in   NUM_DIGITS     decimal point per digit, 1 = lit
//  hold_en         in   1              1 = throttle updates to HOLD_TICKS; 0 = accept any time
//  blank_lz        in   1              1 = blank leading zero digits
//  SEG_SELECT_OUT  out  NUM_DIGITS     digit anodes, active-low one-hot
//  HEX_OUT         out  8              {dp,g..a}, active-low
// BEHAVIOUR
//  Reset: upd_rdy=0, SEG_SELECT_OUT=all 1, HEX_OUT=8'hFF, frame regs=0, all counters=0.
//  - tick: div_cnt counts 0..REFRESH_DIV-1; 1-cycle tick pulse in cycle after div_cnt==REFRESH_DIV-1.
//  - dig_idx: advances on tick, wraps NUM_DIGITS-1 -> 0 (non-power-of-2 counts wrap explicitly).
//  - hold_cnt: counts ticks, saturates at HOLD_TICKS; cleared on accept.
//  - upd_rdy = !rst_q && (!hold_en || hold_cnt==HOLD_TICKS); first frame after reset waits for a full hold
//    when hold_en=1. Accept = upd_vld && upd_rdy; frame regs load on that edge; upd_rdy drops next cycle
//    when hold_en=1. upd_vld with upd_rdy=0 is ignored (no queueing); source holds or drops.
//  - Simultaneous accept and tick: both take effect; hold_cnt clears (accept wins over increment).
//  - Output pipeline: stage 1 registers nibble/dot/blank for dig_idx; stage 2 (seg7_hex_decode) registers
//    SEG_SELECT_OUT/HEX_OUT. Anode and segments change on the same edge, 2 cycles after dig_idx change:
//    no ghosting. Frame change visible from next digit slot at latest.
//  - Leading-zero blank: digit i blanked (HEX_OUT=8'hFF, anode still driven) when blank_lz=1, i>0,
//    dot i=0, and all digits i..NUM_DIGITS-1 have nibble 0 and dot 0. Digit 0 never blanked (0 shows "0").
//  - Reset mid-scan or mid-handshake: everything returns to reset values next edge; in-flight frame dropped.
// CONFIGURATION
//  SEG7_DIMMING_EN defined: extra input bright[3:0]; 4-bit phase counter free-runs on clk_sys;
//    anode asserted only while phase <= bright (bright=15 -> 100 %, 0 -> 1/16 duty); HEX_OUT unchanged.
//  Undefined: no bright port, no phase counter; anode asserted for the whole slot.
// STRUCTURE
//  Package seg7_pkg: typedef seg_t (logic[7:0]), SEG_BLANK=8'hFF, hex->segment localparam table
//    (16 entries, active-low), DIG_W = $clog2(NUM_DIGITS) helper function.
//  Sub-module seg7_hex_decode: registered nibble/dot/blank/idx -> HEX_OUT + one-hot active-low anodes.
// TESTING (sim: REFRESH_DIV=5, HOLD_TICKS=3, NUM_DIGITS=4 unless noted)
//  1 Reset, hold_en=1, upd_vld=1 -> upd_rdy=0 for 15 cycles after tick alignment, rises at 3rd tick; frame
//    16'h12AB accepted once, upd_rdy low next cycle; SEG_SELECT_OUT cycles 1110,1101,1011,0111 -> B,A,2,1.
//  2 hold_en=0, upd_vld every cycle with data 0..9 -> every frame accepted back-to-back, displayed = last.
//  3 blank_lz=1, data 16'h0050, dots 0 -> digits 3,2 HEX_OUT=FF, digit1 "5", digit0 "0"; dots=4'b0100 ->
//    digit 2 shows "0." and is not blanked, digit 3 blanked.
//  4 NUM_DIGITS=6: dig_idx wraps 5->0, anode 6'b011111 then 6'b111110; no idx 6/7 anode ever asserted.
//  5 rst pulse during digit-2 slot with upd_vld high -> next cycle all outputs at reset values, frame regs 0.
//  6 SEG7_DIMMING_EN, bright=3 -> anode low exactly 4 of every 16 cycles; bright=15 -> always low in slot.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types, segment encoding table and sizing helper for the seven-segment scan controller.
package seg7_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK = 8'hFF;

    // {dp,g,f,e,d,c,b,a}, active-low, dp off
    localparam seg_t HEX_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic int dig_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Output stage: turns the registered nibble/dot/blank/index into active-low segments and a
// one-hot active-low anode, both updated on the same edge so there is no ghosting.
module seg7_hex_decode
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIG_W      = 2
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic [3:0]            nib,
    input  logic                  dot,
    input  logic                  blank,
    input  logic [DIG_W-1:0]      idx,
    input  logic                  an_en,
    output logic [7:0]            hex_out,
    output logic [NUM_DIGITS-1:0] seg_sel
);

    seg_t glyph;

    always_comb begin
        glyph = HEX_TABLE[nib];
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            hex_out <= SEG_BLANK;
            seg_sel <= '1;
        end else begin
            hex_out <= blank ? SEG_BLANK : {~dot, glyph[6:0]};
            seg_sel <= an_en ? ~(NUM_DIGITS'(1) << idx) : '1;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed seven-segment controller: throttled frame handshake, refresh-rate digit scan,
// optional leading-zero blanking. Define SEG7_DIMMING_EN to add the bright[3:0] PWM dimming input.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 250000,
    parameter int HOLD_TICKS  = 200
) (
    input  logic                    clk_sys,
    input  logic                    rst,
    input  logic                    upd_vld,
    output logic                    upd_rdy,
    input  logic [4*NUM_DIGITS-1:0] upd_data,
    input  logic [NUM_DIGITS-1:0]   upd_dots,
    input  logic                    hold_en,
    input  logic                    blank_lz,
`ifdef SEG7_DIMMING_EN
    input  logic [3:0]              bright,
`endif
    output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
    output logic [7:0]              HEX_OUT
);

    localparam int DIG_W  = dig_w(NUM_DIGITS);
    localparam int DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    logic                    rst_q;
    logic [DIV_W-1:0]        div_cnt;
    logic                    tick;
    logic [DIG_W-1:0]        dig_idx;
    logic [HOLD_W-1:0]       hold_cnt;
    logic [4*NUM_DIGITS-1:0] frame_data;
    logic [NUM_DIGITS-1:0]   frame_dots;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic                    zero_run;
    logic [3:0]              cur_nib;
    logic                    cur_dot;
    logic                    accept;
    logic [3:0]              s1_nib;
    logic                    s1_dot;
    logic                    s1_blank;
    logic [DIG_W-1:0]        s1_idx;
    logic                    an_en;

    assign upd_rdy = !rst_q && (!hold_en || hold_cnt == HOLD_W'(HOLD_TICKS));
    assign accept  = upd_vld && upd_rdy;

    // A digit is blanked only if it and every more-significant digit is a plain zero.
    always_comb begin
        zero_run  = 1'b1;
        blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run     = zero_run && (frame_data[4*i +: 4] == 4'h0) && !frame_dots[i];
            blank_vec[i] = blank_lz && zero_run;
        end
    end

    always_comb begin
        cur_nib = frame_data[{dig_idx, 2'b00} +: 4];
        cur_dot = frame_dots[dig_idx];
    end

    always_ff @(posedge clk_sys) begin
        rst_q <= rst;
        if (rst) begin
            div_cnt    <= '0;
            tick       <= 1'b0;
            dig_idx    <= '0;
            hold_cnt   <= '0;
            frame_data <= '0;
            frame_dots <= '0;
            s1_nib     <= '0;
            s1_dot     <= 1'b0;
            s1_blank   <= 1'b0;
            s1_idx     <= '0;
        end else begin
            tick    <= (div_cnt == DIV_W'(REFRESH_DIV - 1));
            div_cnt <= (div_cnt == DIV_W'(REFRESH_DIV - 1)) ? '0 : div_cnt + 1'b1;

            if (tick)
                dig_idx <= (dig_idx == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_idx + 1'b1;

            if (accept)
                hold_cnt <= '0;
            else if (tick && hold_cnt != HOLD_W'(HOLD_TICKS))
                hold_cnt <= hold_cnt + 1'b1;

            if (accept) begin
                frame_data <= upd_data;
                frame_dots <= upd_dots;
            end

            s1_nib   <= cur_nib;
            s1_dot   <= cur_dot;
            s1_blank <= blank_vec[dig_idx];
            s1_idx   <= dig_idx;
        end
    end

`ifdef SEG7_DIMMING_EN
    logic [3:0] phase;

    always_ff @(posedge clk_sys) begin
        if (rst)
            phase <= '0;
        else
            phase <= phase + 1'b1;
    end

    assign an_en = (phase <= bright);
`else
    assign an_en = 1'b1;
`endif

    seg7_hex_decode #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIG_W      (DIG_W)
    ) u_decode (
        .clk_sys (clk_sys),
        .rst     (rst),
        .nib     (s1_nib),
        .dot     (s1_dot),
        .blank   (s1_blank),
        .idx     (s1_idx),
        .an_en   (an_en),
        .hex_out (HEX_OUT),
        .seg_sel (SEG_SELECT_OUT)
    );

endmodule
